// File: rtl/gate_response_checker_if.sv
// Vector handshake between the gate stimulus driver and the response checker.
interface gate_response_checker_if #(
  parameter int N_IN = 3
);
  logic            in_valid;
  logic [N_IN-1:0] in_x;
  logic            in_ready;

  modport master (output in_valid, output in_x, input in_ready);
  modport slave  (input in_valid, input in_x, output in_ready);
endinterface

// File: rtl/gate_response_checker.sv
// Gate response checker: accepts applied input vectors, samples the live gate
// output after a fixed settle delay, and compares against an expected truth
// table. Reports pass/fail once every input combination has been observed.
module gate_response_checker #(
  parameter int                   N_IN       = 3,
  parameter logic [(2**N_IN)-1:0] EXP_TABLE  = 8'b0000_0001,
  parameter int                   SETTLE_CYC = 2,
  parameter int                   CNT_W      = 4,
  localparam int                  DEPTH      = 2**N_IN
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  gate_response_checker_if.slave bus,
  input  logic                   dut_a,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [CNT_W-1:0]       err_cnt,
  output logic                   first_err_valid,
  output logic [N_IN-1:0]        first_err_x,
  output logic [DEPTH-1:0]       obs_table,
  output logic [DEPTH-1:0]       seen
);

  typedef enum logic [1:0] {IDLE, COLLECT, SETTLE, DONE} state_t;

  // Settle counter is 4 bits wide, enough for the 1..15 settle range.
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);

  state_t            state_reg;
  logic [3:0]        cnt_reg;
  logic [N_IN-1:0]   x_reg;
  logic              ready_reg;
  logic [DEPTH-1:0]  seen_upd;
  logic              mismatch;
  logic [CNT_W-1:0]  err_upd;

  assign bus.in_ready = ready_reg;

  // Seen table as it will look after the pending sample is recorded.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_seen
      assign seen_upd[gi] = seen[gi] | (x_reg == N_IN'(gi));
    end
  endgenerate

  // Mismatch detection and saturating error-count increment for the sample.
  always_comb begin
    mismatch = (dut_a != EXP_TABLE[x_reg]);
    err_upd  = err_cnt;
    if (mismatch && (err_cnt != {CNT_W{1'b1}})) begin
      err_upd = err_cnt + CNT_W'(1);
    end
  end

  // Session FSM with registered handshake, status and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      x_reg           <= '0;
      ready_reg       <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_x     <= '0;
      obs_table       <= '0;
      seen            <= '0;
    end else if (start) begin
      // Restart from any state; an in-flight sample is simply dropped.
      state_reg       <= COLLECT;
      ready_reg       <= 1'b1;
      busy            <= 1'b1;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_x     <= '0;
      obs_table       <= '0;
      seen            <= '0;
    end else begin
      case (state_reg)
        COLLECT: begin
          if (bus.in_valid) begin
            x_reg     <= bus.in_x;
            cnt_reg   <= SETTLE_LD;
            ready_reg <= 1'b0;
            state_reg <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_reg == 4'd1) begin
            obs_table[x_reg] <= dut_a;
            seen             <= seen_upd;
            err_cnt          <= err_upd;
            if (mismatch && !first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_x     <= x_reg;
            end
            if (&seen_upd) begin
              state_reg <= DONE;
              done      <= 1'b1;
              pass      <= (err_upd == '0);
              busy      <= 1'b0;
            end else begin
              state_reg <= COLLECT;
              ready_reg <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        IDLE, DONE: begin
          // Hold until start or reset.
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/gate_response_checker.md
Name: gate_response_checker

Overview:
- Response-side counterpart to the truth-table stimulus sweep used on the CMOS gate cells.
- Accepts applied input vectors over a valid/ready handshake and samples the live gate output after a settle delay.
- Compares each sample against an expected truth table, builds the observed table and flags errors.
- Reports pass/fail once every input combination has been seen, enabling self-checking gate tests in hardware and simulation.

Parameters:
- N_IN, 3, gate input count; table depth is 2**N_IN (8).
- EXP_TABLE, 8'b0000_0001, expected output per input index (bit i = expected a for x=i); default is NOR3.
- SETTLE_CYC, 2, cycles from vector acceptance to output sample; legal range 1..15.
- CNT_W, 4, error counter width.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous active-low reset.
- start, input, 1, one-cycle pulse; clears results and begins a session.
- in_valid, input, 1, in_x holds the vector now applied to the gate.
- in_x, input, N_IN, applied input vector.
- in_ready, output, 1, checker will accept a vector this cycle.
- dut_a, input, 1, live gate output.
- busy, output, 1, session in progress.
- done, output, 1, all 2**N_IN vectors checked.
- pass, output, 1, done with zero errors.
- err_cnt, output, CNT_W, saturating mismatch count.
- first_err_valid, output, 1, at least one mismatch recorded.
- first_err_x, output, N_IN, vector of first mismatch.
- obs_table, output, 2**N_IN, last sampled dut_a per vector.
- seen, output, 2**N_IN, vectors checked so far.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a clk edge): state IDLE; all outputs 0; applies mid-session with no partial results retained.
- States: IDLE, COLLECT, SETTLE, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - start -> COLLECT; on the same edge, clear seen, obs_table, err_cnt, first_err_valid, first_err_x, done and pass.
- COLLECT:
  - in_ready=1, busy=1.
  - Accept on in_valid&in_ready: latch in_x into x_q, load settle counter with SETTLE_CYC, go to SETTLE.
- SETTLE:
  - in_ready=0; in_valid and in_x are ignored.
  - The counter decrements each edge. dut_a is sampled on the edge exactly SETTLE_CYC cycles after the acceptance edge; dut_a activity before that edge has no effect.
  - On the sample edge:
    - obs_table[x_q] <= dut_a; seen[x_q] <= 1.
    - If dut_a != EXP_TABLE[x_q]: err_cnt increments, saturating at 2**CNT_W-1. If first_err_valid=0, set first_err_valid=1 and first_err_x <= x_q.
    - If seen, including this update, is all ones: go to DONE, done=1, pass=(updated err_cnt==0).
    - Otherwise return to COLLECT; in_ready is 1 on the next cycle.
- Repeated vectors:
  - A vector may repeat; it is re-checked, may count again, and its obs_table entry is overwritten.
  - Repeats never complete the session early.
- DONE:
  - busy=0, in_ready=0.
  - Results hold until start or reset.
- start in COLLECT, SETTLE or DONE:
  - Restarts the session. The same clears as in IDLE apply and the next state is COLLECT.
  - An in-flight sample is discarded.
  - start has priority over acceptance and sampling on the same edge.
- Output timing: all outputs are registered; no combinational path from inputs to outputs except none (in_ready is decoded from state only).
- Throughput: one vector per SETTLE_CYC+1 cycles.

Test Plan:
- Correct NOR3, SETTLE_CYC=2, start then x=0..7 back-to-back with dut_a driven correctly -> each accept spaced 3 cycles apart, done=1 on the 8th sample edge, pass=1, err_cnt=0, obs_table=8'h01, seen=8'hFF.
- Faulty gate with dut_a=1 at x=3 and x=5 -> err_cnt=2, first_err_valid=1, first_err_x=3, obs_table=8'h29, pass=0, done=1.
- Order x=7,0,0,3,1,2,4,6,5 -> done stays 0 until the 9th sample (x=5); duplicate x=0 sampled twice; final seen=8'hFF.
- Settle timing, SETTLE_CYC=3: dut_a wrong for the first 2 cycles after accept, correct on the 3rd edge -> no error. Also in_valid held high during SETTLE -> no extra accepts, in_ready=0.
- Saturation, CNT_W=2: x=5 with wrong dut_a repeated 5 times -> err_cnt=3, stays 3, done=0.
- Interruptions:
  - rst_n=0 for one edge after 4 vectors -> all outputs 0, state IDLE.
  - start during SETTLE -> seen=0, pending sample discarded, in_ready=1 next cycle.
  - start in DONE -> new session begins.
